// File: rtl/spectrum_bar_writer_if.sv
// Bar-write handshake from the complementer plus the frame-buffer write port.
// master = upstream/driver side, slave = spectrum_bar_writer.
interface spectrum_bar_writer_if #(
    parameter int ADDR_W = 10
);
    logic              frame_start;
    logic              sw_start;
    logic [6:0]        in_bar;
    logic              sw_busy;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;

    modport master (
        output frame_start, sw_start, in_bar,
        input  sw_busy, mem_we, mem_addr, mem_data
    );

    modport slave (
        input  frame_start, sw_start, in_bar,
        output sw_busy, mem_we, mem_addr, mem_data
    );
endinterface

// File: rtl/spectrum_bar_writer.sv
// Rasterizes one bar plus a decaying peak-hold dot into a packed frame-buffer column.
// state   | meaning
// S_IDLE  | waiting for sw_start; frame_start rewinds the column counter
// S_PEAK  | update peak/hold for the column, emit word 0
// S_WRITE | emit words 1..HEIGHT/8-1, then advance the column
module spectrum_bar_writer #(
    parameter int NUM_COLS = 64,
    parameter int HEIGHT   = 128,
    parameter int HOLD     = 15,
    parameter int ADDR_W   = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    spectrum_bar_writer_if.slave  bus
);
    localparam int WPC    = HEIGHT / 8;
    localparam int WORD_W = (WPC > 1) ? $clog2(WPC) : 1;
    localparam int COL_W  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int HOLD_W = (HOLD > 0) ? $clog2(HOLD + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_PEAK, S_WRITE} state_t;

    state_t              r_state, w_state_nxt;
    logic [COL_W-1:0]    r_col;
    logic [6:0]          r_bar;
    logic [WORD_W-1:0]   r_word;
    logic                r_fs_pend;
    logic [7:0]          r_peak [NUM_COLS];
    logic [HOLD_W-1:0]   r_hold [NUM_COLS];
    logic                r_busy, r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_data;

    logic                w_last;
    logic [7:0]          w_bar_clamp, w_peak_old, w_peak_new, w_peak_use;
    logic [HOLD_W-1:0]   w_hold_old, w_hold_new;
    logic [WORD_W-1:0]   w_word_emit;
    logic [ADDR_W-1:0]   w_addr;
    logic [7:0]          w_data;
    logic [COL_W-1:0]    w_col_next;

    assign w_last = (r_word == WORD_W'(WPC - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.sw_start) w_state_nxt = S_PEAK;
            S_PEAK:  w_state_nxt = S_WRITE;
            S_WRITE: if (w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Peak/hold update; only committed in S_PEAK, but word 0 needs the new value.
    always_comb begin
        w_peak_old  = r_peak[r_col];
        w_hold_old  = r_hold[r_col];
        w_bar_clamp = ({1'b0, r_bar} >= 8'(HEIGHT)) ? 8'(HEIGHT) : {1'b0, r_bar};
        w_peak_new  = w_peak_old;
        w_hold_new  = w_hold_old;
        if (w_bar_clamp >= w_peak_old) begin
            w_peak_new = w_bar_clamp;
            w_hold_new = HOLD_W'(HOLD);
        end else if (w_hold_old != '0) begin
            w_hold_new = w_hold_old - HOLD_W'(1);
        end else if (w_peak_old != 8'd0) begin
            w_peak_new = w_peak_old - 8'd1;
        end
    end

    always_comb begin
        logic [7:0] row;
        w_peak_use  = (r_state == S_PEAK) ? w_peak_new : w_peak_old;
        w_word_emit = (r_state == S_PEAK) ? '0 : r_word + WORD_W'(1);
        w_addr      = ADDR_W'(r_col) * ADDR_W'(WPC) + ADDR_W'(w_word_emit);
        w_data      = 8'h00;
        row         = 8'h00;
        for (int j = 0; j < 8; j++) begin
            row       = 8'({w_word_emit, 3'(j)});
            w_data[j] = (row < {1'b0, r_bar}) ||
                        ((w_peak_use != 8'd0) && (row == w_peak_use - 8'd1));
        end
    end

    assign w_col_next = (r_fs_pend || bus.frame_start || (r_col == COL_W'(NUM_COLS - 1)))
                        ? '0 : r_col + COL_W'(1);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_col     <= '0;
            r_bar     <= '0;
            r_word    <= '0;
            r_fs_pend <= 1'b0;
            r_busy    <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            for (int i = 0; i < NUM_COLS; i++) begin
                r_peak[i] <= '0;
                r_hold[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.frame_start) r_col <= '0;
                    if (bus.sw_start) begin
                        r_bar     <= bus.in_bar;
                        r_busy    <= 1'b1;
                        r_fs_pend <= 1'b0;
                    end
                end
                S_PEAK: begin
                    r_peak[r_col] <= w_peak_new;
                    r_hold[r_col] <= w_hold_new;
                    r_word        <= '0;
                    r_we          <= 1'b1;
                    r_addr        <= w_addr;
                    r_data        <= w_data;
                    if (bus.frame_start) r_fs_pend <= 1'b1;
                end
                S_WRITE: begin
                    if (w_last) begin
                        r_we      <= 1'b0;
                        r_busy    <= 1'b0;
                        r_fs_pend <= 1'b0;
                        r_col     <= w_col_next;
                    end else begin
                        r_word <= r_word + WORD_W'(1);
                        r_addr <= w_addr;
                        r_data <= w_data;
                        if (bus.frame_start) r_fs_pend <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sw_busy  = r_busy;
    assign bus.mem_we   = r_we;
    assign bus.mem_addr = r_addr;
    assign bus.mem_data = r_data;
endmodule
